// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter: ALU (A, younger) and load (B, older) share one port.
// Contention uses fixed B priority with A starvation relief; define WB_ARB_RR_EN for round-robin.
module wb_arbiter #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              a_valid_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              a_ready_o,
   input  logic              b_valid_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              b_ready_o,
   output logic              w_enable_o,
   output logic [ADDR_W-1:0] w_addr_o,
   output logic [DATA_W-1:0] w_data_o,
   output logic [15:0]       wr_count_o
);

   logic              go;
   logic              a_nz, b_nz;
   logic              same_addr, contend, contend_gnt;
   logic              pick_a;
   logic              w_en_q, w_en_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [15:0]       cnt_q, cnt_d;

   assign go          = rst & ~stall_i;
   assign a_nz        = a_valid_i & (a_addr_i != '0);
   assign b_nz        = b_valid_i & (b_addr_i != '0);
   assign same_addr   = a_nz & b_nz & (a_addr_i == b_addr_i);
   assign contend     = a_nz & b_nz & ~same_addr;
   assign contend_gnt = go & contend;

   // Address-0 requests and same-address pairs never consume the port, so both are acked.
   assign a_ready_o = go & a_valid_i & (~a_nz | ~b_nz | same_addr | (contend & pick_a));
   assign b_ready_o = go & b_valid_i & (~b_nz | ~a_nz | same_addr | (contend & ~pick_a));

`ifdef WB_ARB_RR_EN
   logic rr_q, rr_d;

   assign pick_a = rr_q;

   always_comb begin
      rr_d = rr_q;
      if (contend_gnt) begin
         rr_d = ~rr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

   logic [CntW-1:0] starve_q, starve_d;

   assign pick_a = (starve_q >= StarveMax);

   always_comb begin
      starve_d = starve_q;
      if (!a_valid_i || a_ready_o) begin
         starve_d = '0;
      end else if (contend_gnt) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   // A is checked first so a same-address pair commits the younger result.
   always_comb begin
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      cnt_d    = cnt_q;
      if (a_ready_o && a_nz) begin
         w_en_d   = 1'b1;
         w_addr_d = a_addr_i;
         w_data_d = a_data_i;
      end else if (b_ready_o && b_nz) begin
         w_en_d   = 1'b1;
         w_addr_d = b_addr_i;
         w_data_d = b_data_i;
      end
      if (w_en_d) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         cnt_q    <= '0;
      end else begin
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         cnt_q    <= cnt_d;
      end
   end

   assign w_enable_o = w_en_q;
   assign w_addr_o   = w_addr_q;
   assign w_data_o   = w_data_q;
   assign wr_count_o = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, grant-pattern sequence, randomized model check
// and write-counter wrap. Expectations follow WB_ARB_RR_EN when it is defined.
module tb_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall = 1'b0;
   logic          av = 1'b0, bv = 1'b0;
   logic [AW-1:0] aa = '0, ba = '0;
   logic [DW-1:0] ad = '0, bd = '0;
   logic          ar, br, we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic [15:0]   cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .a_valid_i  (av),
      .a_addr_i   (aa),
      .a_data_i   (ad),
      .a_ready_o  (ar),
      .b_valid_i  (bv),
      .b_addr_i   (ba),
      .b_data_i   (bd),
      .b_ready_o  (br),
      .w_enable_o (we),
      .w_addr_o   (wa),
      .w_data_o   (wd),
      .wr_count_o (cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input bit r, input bit s, input bit a_v, input int a_a, input int a_d,
                        input bit b_v, input int b_a, input int b_d);
      rst   = r;
      stall = s;
      av    = a_v;
      aa    = AW'(a_a);
      ad    = DW'(a_d);
      bv    = b_v;
      ba    = AW'(b_a);
      bd    = DW'(b_d);
   endtask

   // Reference model state
   bit            m_prefa = 1'b0;
   int            m_streak = 0;
   bit            m_we = 1'b0;
   logic [AW-1:0] m_wa = '0;
   logic [DW-1:0] m_wd = '0;
   logic [15:0]   m_cnt = '0;

   // One cycle against the model: readies before the edge, registered outputs after it.
   task automatic model_cycle(input string tag, output bit got_a);
      bit ear, ebr, wr, cont, pick_a;
      logic [AW-1:0] nwa;
      logic [DW-1:0] nwd;
      ear = 0; ebr = 0; wr = 0; cont = 0; pick_a = 0;
      nwa = m_wa;
      nwd = m_wd;
      if (rst && !stall) begin
         if (av && bv && aa != 0 && ba != 0 && aa != ba) begin
            cont = 1;
`ifdef WB_ARB_RR_EN
            pick_a = m_prefa;
`else
            pick_a = (m_streak >= SM);
`endif
            ear = pick_a;
            ebr = !pick_a;
         end else begin
            ear = av;
            ebr = bv;
         end
         if (ear && aa != 0) begin
            wr = 1; nwa = aa; nwd = ad;
         end else if (ebr && ba != 0) begin
            wr = 1; nwa = ba; nwd = bd;
         end
      end
      #2;
      got_a = ar;
      chk($sformatf("%s a_ready", tag), 32'(ar), 32'(ear));
      chk($sformatf("%s b_ready", tag), 32'(br), 32'(ebr));
      @(posedge clk);
      #1;
      if (!rst) begin
         m_prefa = 0; m_streak = 0; m_we = 0; m_wa = '0; m_wd = '0; m_cnt = '0;
      end else begin
         if (cont) m_prefa = !m_prefa;
         if (!av || ear) m_streak = 0;
         else if (cont) m_streak++;
         m_we = wr;
         if (wr) begin
            m_wa  = nwa;
            m_wd  = nwd;
            m_cnt = m_cnt + 16'd1;
         end
      end
      chk($sformatf("%s w_enable", tag), 32'(we), 32'(m_we));
      chk($sformatf("%s w_addr", tag), 32'(wa), 32'(m_wa));
      chk($sformatf("%s w_data", tag), wd, m_wd);
      chk($sformatf("%s wr_count", tag), 32'(cnt), 32'(m_cnt));
   endtask

   typedef struct {
      bit r, s, a_v; int a_a, a_d;
      bit b_v; int b_a, b_d;
      bit ear, ebr, ewe; int ewa, ewd, ecnt;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl[NV];

`ifdef WB_ARB_RR_EN
   bit pat_a[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
   bit pat_a[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif

   initial begin
      bit ga;
      //          r s av aa ad    bv ba bd    ar br we wa wd    cnt
      tbl[0]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,    0};
      tbl[1]  = '{1, 0, 1, 3, 'h11, 0, 0, 0,    1, 0, 1, 3, 'h11, 1};
      tbl[2]  = '{1, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 3, 'h11, 1};
      tbl[3]  = '{1, 0, 1, 4, 'hAA, 1, 4, 'hBB, 1, 1, 1, 4, 'hAA, 2};
      tbl[4]  = '{1, 0, 1, 0, 'h55, 1, 7, 'h77, 1, 1, 1, 7, 'h77, 3};
      tbl[5]  = '{1, 1, 1, 0, 'h55, 1, 7, 'h77, 0, 0, 0, 7, 'h77, 3};
      tbl[6]  = '{1, 0, 1, 0, 'h66, 0, 0, 0,    1, 0, 0, 7, 'h77, 3};
      tbl[7]  = '{1, 0, 0, 0, 0,    1, 9, 'h99, 0, 1, 1, 9, 'h99, 4};
      tbl[8]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,    0};
      tbl[9]  = '{0, 0, 0, 0, 0,    1, 5, 'h44, 0, 0, 0, 0, 0,    0};
      tbl[10] = '{1, 0, 0, 0, 0,    1, 2, 'h22, 0, 1, 1, 2, 'h22, 1};

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i].r, tbl[i].s, tbl[i].a_v, tbl[i].a_a, tbl[i].a_d,
               tbl[i].b_v, tbl[i].b_a, tbl[i].b_d);
         #2;
         chk($sformatf("vec%0d a_ready", i), 32'(ar), 32'(tbl[i].ear));
         chk($sformatf("vec%0d b_ready", i), 32'(br), 32'(tbl[i].ebr));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d w_enable", i), 32'(we), 32'(tbl[i].ewe));
         chk($sformatf("vec%0d w_addr", i), 32'(wa), tbl[i].ewa);
         chk($sformatf("vec%0d w_data", i), wd, tbl[i].ewd);
         chk($sformatf("vec%0d wr_count", i), 32'(cnt), tbl[i].ecnt);
      end

      // Continuous contention between distinct nonzero addresses
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      model_cycle("pat_rst", ga);
      apply(1, 0, 1, 1, 'hA1, 1, 2, 'hB2);
      for (int i = 0; i < 8; i++) begin
         model_cycle($sformatf("pat%0d", i), ga);
         chk($sformatf("pat%0d grant_a", i), 32'(ga), 32'(pat_a[i]));
      end

      // Randomized traffic against the model
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      model_cycle("rnd_rst", ga);
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom),
               $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom));
         model_cycle($sformatf("rnd%0d", i), ga);
      end

      // Write counter wrap
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      apply(1, 0, 1, 1, 5, 0, 0, 0);
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap wr_count_ffff", 32'(cnt), 32'hFFFF);
      @(posedge clk);
      #1;
      chk("wrap wr_count_zero", 32'(cnt), 32'h0);
      chk("wrap w_enable", 32'(we), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
